// File: rtl/seven_segment_scan_decoder.sv
// Reads back a multiplexed active-low 7-segment bus and holds one debounced BCD code per digit.
// Each capture needs a settled one-hot select window, and each commit needs repeated identical captures.
module seven_segment_scan_decoder #(
   parameter int unsigned NUM_DIGITS    = 8,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned STABLE_SCANS  = 2
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [NUM_DIGITS-1:0]   AN,
   input  logic [6:0]              SEG,
   output logic [4*NUM_DIGITS-1:0] DIGITS,
   output logic [NUM_DIGITS-1:0]   DIGIT_VALID,
   output logic [NUM_DIGITS-1:0]   ERR,
   output logic                    UPDATE
);

   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned SW = $clog2(STABLE_SCANS + 1);
   localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYCLES);
   localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_SCANS);

   logic [NUM_DIGITS-1:0] r_an_q;
   logic [6:0]            r_seg_q;
   logic [CW-1:0]         r_settle;
   logic [3:0]            r_cand [NUM_DIGITS];
   logic [SW-1:0]         r_cnt  [NUM_DIGITS];
   logic [3:0]            r_dig  [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] r_valid;
   logic [NUM_DIGITS-1:0] r_err;
   logic                  r_update;
   logic                  r_pend;
   logic [IW-1:0]         r_pend_idx;
   logic [3:0]            r_pend_code;

   logic [NUM_DIGITS-1:0] w_an_n;
   logic                  w_legal;
   logic                  w_same;
   logic                  w_capture;
   logic [IW-1:0]         w_idx;
   logic [3:0]            w_code;
   logic                  w_match;
   logic [SW-1:0]         w_cnt_nxt;

   // Settle tracking compares the incoming select against AN_q, so the counter
   // moves on the same edge that loads AN_q and capture lands on edge SETTLE_CYCLES.
   always_comb begin
      w_an_n  = ~AN;
      w_legal = (w_an_n != '0) && ((w_an_n & (w_an_n - 1'b1)) == '0);
      w_same  = (AN == r_an_q);
      w_capture = w_legal && w_same && (r_settle == SETTLE_MAX - 1'b1);
      w_idx = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (w_an_n[i]) w_idx = IW'(i);
      end
   end

   always_comb begin
      unique case (r_seg_q)
         7'b0000001: w_code = 4'h0;
         7'b1001111: w_code = 4'h1;
         7'b0010010: w_code = 4'h2;
         7'b0000110: w_code = 4'h3;
         7'b1001100: w_code = 4'h4;
         7'b0100100: w_code = 4'h5;
         7'b0100000: w_code = 4'h6;
         7'b0001111: w_code = 4'h7;
         7'b0000000: w_code = 4'h8;
         7'b0000100: w_code = 4'h9;
         7'b1111111: w_code = 4'hF;
         default:    w_code = 4'hE;
      endcase
   end

   always_comb begin
      w_match   = (w_code == r_cand[w_idx]);
      w_cnt_nxt = 1'b1;
      if (w_match) begin
         w_cnt_nxt = (r_cnt[w_idx] == STABLE_MAX) ? STABLE_MAX : r_cnt[w_idx] + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_an_q      <= '1;
         r_seg_q     <= '1;
         r_settle    <= '0;
         r_valid     <= '0;
         r_err       <= '0;
         r_update    <= 1'b0;
         r_pend      <= 1'b0;
         r_pend_idx  <= '0;
         r_pend_code <= 4'hF;
         for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            r_cand[i] <= 4'hF;
            r_cnt[i]  <= '0;
            r_dig[i]  <= 4'hF;
         end
      end else begin
         r_an_q   <= AN;
         r_seg_q  <= SEG;
         r_update <= 1'b0;

         if (!w_legal || !w_same) r_settle <= '0;
         else if (r_settle != SETTLE_MAX) r_settle <= r_settle + 1'b1;

         r_pend <= 1'b0;
         if (w_capture) begin
            r_cand[w_idx] <= w_code;
            r_cnt[w_idx]  <= w_cnt_nxt;
            r_pend        <= (w_cnt_nxt == STABLE_MAX);
            r_pend_idx    <= w_idx;
            r_pend_code   <= w_code;
         end

         if (r_pend && (!r_valid[r_pend_idx] || r_pend_code != r_dig[r_pend_idx])) begin
            r_dig[r_pend_idx]   <= r_pend_code;
            r_valid[r_pend_idx] <= 1'b1;
            r_err[r_pend_idx]   <= (r_pend_code == 4'hE);
            r_update            <= 1'b1;
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) DIGITS[4*i +: 4] = r_dig[i];
   end

   assign DIGIT_VALID = r_valid;
   assign ERR         = r_err;
   assign UPDATE      = r_update;

endmodule
